// File: rtl/hamming_secded_corrector.sv
// ---------------------------------------------------------------------------
// hamming_secded_corrector
//
// Pipelined Hamming SEC / SEC-DED decoder with valid/ready streaming on both
// sides, per-word error flags and saturating error statistics.
//
// Codeword layout: in_code[i] is Hamming position i+1. Check bits sit at the
// power-of-two positions, data bits fill the remaining positions in ascending
// order. With SECDED=1, in_code[HAM_W] is the overall parity bit.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   input handshake, in_code = received codeword
//   out_valid/out_ready output handshake
//   out_data            corrected information bits (LSB = lowest data position)
//   out_syndrome        Hamming syndrome of the delivered word
//   out_corrected       single error corrected (incl. overall parity bit error)
//   out_uncorrectable   double error, or syndrome beyond HAM_W
//   clear_cnt           synchronous clear of both statistics counters
//   corr_count          saturating count of delivered corrected words
//   uncorr_count        saturating count of delivered uncorrectable words
//
// Handshake: a word moves across an interface on a cycle where valid and
// ready are both high. A producer holds valid and its payload steady until
// the transfer. Each stage advances when it is empty or its downstream
// stage advances (s2_adv = !out_valid | out_ready; s1_adv = !s1_valid |
// s2_adv), and in_ready is s1_adv, so no word is dropped or duplicated and
// the output registers hold while out_valid & !out_ready.
// ---------------------------------------------------------------------------
module hamming_secded_corrector #(
    parameter  int DATA_W = 4,
    parameter  int PAR_W  = 3,
    parameter  int SECDED = 1,
    parameter  int CNT_W  = 8,
    localparam int HAM_W  = DATA_W + PAR_W,
    localparam int CODE_W = HAM_W + SECDED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [PAR_W-1:0]  out_syndrome,
    output logic              out_corrected,
    output logic              out_uncorrectable,
    input  logic              clear_cnt,
    output logic [CNT_W-1:0]  corr_count,
    output logic [CNT_W-1:0]  uncorr_count
);

    generate
        if ((1 << PAR_W) < HAM_W + 1) begin : g_bad_params
            $error("hamming_secded_corrector: PAR_W too small for DATA_W");
        end
    endgenerate

    logic s1_adv;
    logic s2_adv;
    logic out_fire;

    // Stage 1 state
    logic              s1_valid_q;
    logic [HAM_W-1:0]  s1_code_q;
    logic [PAR_W-1:0]  s1_syn_q;
    logic              s1_par_q;
    logic [PAR_W-1:0]  s1_syn_d;
    logic              s1_par_d;

    // Stage 2 state
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [PAR_W-1:0]  out_syn_q;
    logic              out_corr_q;
    logic              out_uncorr_q;
    logic [DATA_W-1:0] out_data_d;
    logic              out_corr_d;
    logic              out_uncorr_d;

    logic [CNT_W-1:0]  corr_cnt_q;
    logic [CNT_W-1:0]  uncorr_cnt_q;
    logic [CNT_W-1:0]  corr_cnt_d;
    logic [CNT_W-1:0]  uncorr_cnt_d;

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign out_fire = out_valid_q && out_ready;

    // Syndrome is the XOR of the positions of all set bits; a clean
    // codeword gives zero, a single error gives the erroneous position.
    always_comb begin
        s1_syn_d = '0;
        for (int i = 0; i < HAM_W; i++) begin
            if (in_code[i]) begin
                s1_syn_d = s1_syn_d ^ PAR_W'(i + 1);
            end
        end
        s1_par_d = (SECDED != 0) ? ^in_code : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_code_q  <= '0;
            s1_syn_q   <= '0;
            s1_par_q   <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_code_q <= in_code[HAM_W-1:0];
                s1_syn_q  <= s1_syn_d;
                s1_par_q  <= s1_par_d;
            end
        end
    end

    // Classification and correction. With SECDED, a nonzero syndrome with
    // even overall parity means two bits flipped; a zero syndrome with odd
    // parity means only the overall parity bit itself flipped.
    always_comb begin
        logic [HAM_W-1:0] fixed;
        logic             flip_en;
        int               k;
        fixed        = s1_code_q;
        flip_en      = 1'b0;
        out_corr_d   = 1'b0;
        out_uncorr_d = 1'b0;
        out_data_d   = '0;
        k            = 0;
        if ((SECDED != 0) && (s1_syn_q != '0) && !s1_par_q) begin
            out_uncorr_d = 1'b1;
        end else if (s1_syn_q == '0) begin
            out_corr_d = s1_par_q;
        end else if (int'(s1_syn_q) > HAM_W) begin
            out_uncorr_d = 1'b1;
        end else begin
            out_corr_d = 1'b1;
            flip_en    = 1'b1;
        end
        for (int i = 0; i < HAM_W; i++) begin
            if (flip_en && (PAR_W'(i + 1) == s1_syn_q)) begin
                fixed[i] = ~fixed[i];
            end
        end
        // Gather data bits from the non-power-of-two positions.
        for (int pos = 1; pos <= HAM_W; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                out_data_d[k] = fixed[pos-1];
                k = k + 1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_syn_q    <= '0;
            out_corr_q   <= 1'b0;
            out_uncorr_q <= 1'b0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_data_q   <= out_data_d;
                out_syn_q    <= s1_syn_q;
                out_corr_q   <= out_corr_d;
                out_uncorr_q <= out_uncorr_d;
            end
        end
    end

    // Statistics count delivered words only; clear wins over an increment.
    always_comb begin
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        if (clear_cnt) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end else if (out_fire) begin
            if (out_corr_q && (corr_cnt_q != '1)) begin
                corr_cnt_d = corr_cnt_q + 1'b1;
            end
            if (out_uncorr_q && (uncorr_cnt_q != '1)) begin
                uncorr_cnt_d = uncorr_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign out_valid         = out_valid_q;
    assign out_data          = out_data_q;
    assign out_syndrome      = out_syn_q;
    assign out_corrected     = out_corr_q;
    assign out_uncorrectable = out_uncorr_q;
    assign corr_count        = corr_cnt_q;
    assign uncorr_count      = uncorr_cnt_q;

endmodule
